// File: rtl/fp_adder.sv
// Two-stage IEEE-754 binary32 adder (round-to-nearest-even, FTZ/DAZ): align/add, then normalise/round.
// Optional feature macro FP_ADDER_FLAGS_EN adds a registered flags[3:0] = {invalid, overflow, underflow, inexact} port.
module fp_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] number_1,
    input  logic [31:0] number_2,
`ifdef FP_ADDER_FLAGS_EN
    output logic [3:0]  flags,
`endif
    output logic        out_valid,
    output logic [31:0] out
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned SIG_W  = FRAC_W + 1;
    localparam int unsigned EXT_W  = SIG_W + 3;
    localparam int unsigned SUM_W  = EXT_W + 1;
    localparam int unsigned PAD_W  = 26;
    localparam int unsigned WIDE_W = SIG_W + PAD_W;
    localparam int unsigned ESGN_W = EXP_W + 2;
    localparam int unsigned LZC_W  = 5;

    localparam logic [EXP_W-1:0] EXP_MAX   = '1;
    localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(PAD_W);
    localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

    // Leading-zero count of the 27-bit extended significand.
    function automatic logic [LZC_W-1:0] lzc27(input logic [EXT_W-1:0] v);
        logic [LZC_W-1:0] n;
        logic             found;
        n     = LZC_W'(EXT_W);
        found = 1'b0;
        for (int i = int'(EXT_W) - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LZC_W'(int'(EXT_W) - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: classify, order by magnitude, align and add/subtract
    // ------------------------------------------------------------------
    logic              n1_zero, n2_zero, n1_inf, n2_inf, n1_nan, n2_nan;
    logic [30:0]       n1_mag, n2_mag;
    logic              swap;
    logic [31:0]       op_big, op_small;
    logic [EXP_W-1:0]  exp_diff;
    logic [SIG_W-1:0]  big_sig, small_sig;
    logic [WIDE_W-1:0] shift_wide;
    logic [EXT_W-1:0]  big_ext, small_aln;

    logic              s1_valid_q;
    logic              s1_sign_d,     s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_d,      s1_exp_q;
    logic [SUM_W-1:0]  s1_sum_d,      s1_sum_q;
    logic              s1_special_d,  s1_special_q;
    logic [31:0]       s1_spec_val_d, s1_spec_val_q;
    logic              s1_invalid_d;

    assign n1_zero = (number_1[30:23] == '0);
    assign n2_zero = (number_2[30:23] == '0);
    assign n1_inf  = (number_1[30:23] == EXP_MAX) && (number_1[22:0] == '0);
    assign n2_inf  = (number_2[30:23] == EXP_MAX) && (number_2[22:0] == '0);
    assign n1_nan  = (number_1[30:23] == EXP_MAX) && (number_1[22:0] != '0);
    assign n2_nan  = (number_2[30:23] == EXP_MAX) && (number_2[22:0] != '0);

    // Subnormal inputs read as zero magnitude for ordering.
    assign n1_mag = n1_zero ? '0 : number_1[30:0];
    assign n2_mag = n2_zero ? '0 : number_2[30:0];
    assign swap   = (n2_mag > n1_mag);

    assign op_big    = swap ? number_2 : number_1;
    assign op_small  = swap ? number_1 : number_2;
    assign big_sig   = {1'b1, op_big[22:0]};
    assign small_sig = {1'b1, op_small[22:0]};
    assign exp_diff  = op_big[30:23] - op_small[30:23];
    assign big_ext   = {big_sig, 3'b000};

    // Bits shifted below the round position collapse into sticky.
    assign shift_wide = {small_sig, PAD_W'(0)} >> exp_diff;
    assign small_aln  = (exp_diff >= SHIFT_LIM)
                      ? {(EXT_W-1)'(0), |small_sig}
                      : {shift_wide[WIDE_W-1:WIDE_W-SIG_W-2], |shift_wide[WIDE_W-SIG_W-3:0]};

    always_comb begin : stage1_datapath
        s1_sign_d = op_big[31];
        s1_exp_d  = op_big[30:23];
        if (op_big[31] == op_small[31]) begin
            s1_sum_d = {1'b0, big_ext} + {1'b0, small_aln};
        end else begin
            s1_sum_d = {1'b0, big_ext} - {1'b0, small_aln};
        end
    end

    // Results that bypass the arithmetic path.
    always_comb begin : stage1_special
        s1_special_d  = 1'b1;
        s1_spec_val_d = '0;
        s1_invalid_d  = 1'b0;
        if (n1_nan || n2_nan) begin
            s1_spec_val_d = QNAN;
            s1_invalid_d  = 1'b1;
        end else if (n1_inf && n2_inf && (number_1[31] != number_2[31])) begin
            s1_spec_val_d = QNAN;
            s1_invalid_d  = 1'b1;
        end else if (n1_inf) begin
            s1_spec_val_d = number_1;
        end else if (n2_inf) begin
            s1_spec_val_d = number_2;
        end else if (n1_zero && n2_zero) begin
            s1_spec_val_d = {number_1[31] & number_2[31], 31'd0};
        end else if (n1_zero) begin
            s1_spec_val_d = number_2;
        end else if (n2_zero) begin
            s1_spec_val_d = number_1;
        end else begin
            s1_special_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin : stage1_regs
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_exp_q      <= '0;
            s1_sum_q      <= '0;
            s1_special_q  <= 1'b0;
            s1_spec_val_q <= '0;
        end else begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_sign_q     <= s1_sign_d;
                s1_exp_q      <= s1_exp_d;
                s1_sum_q      <= s1_sum_d;
                s1_special_q  <= s1_special_d;
                s1_spec_val_q <= s1_spec_val_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: normalise, round to nearest even, range check
    // ------------------------------------------------------------------
    logic [LZC_W-1:0]         lzc;
    logic [EXT_W-1:0]         norm;
    logic signed [ESGN_W-1:0] exp_base, exp_n, exp_r;
    logic                     round_up;
    logic [SIG_W:0]           mant_r;
    logic [FRAC_W-1:0]        mant_f;
    logic                     sum_zero, ovf_c, unf_c;
    logic [31:0]              out_d;
    logic                     out_valid_q;
    logic [31:0]              out_q;

    always_comb begin : stage2_norm_round
        lzc      = lzc27(s1_sum_q[EXT_W-1:0]);
        exp_base = signed'(ESGN_W'(s1_exp_q));
        if (s1_sum_q[SUM_W-1]) begin
            norm  = {s1_sum_q[SUM_W-1:2], s1_sum_q[1] | s1_sum_q[0]};
            exp_n = exp_base + 10'sd1;
        end else begin
            norm  = s1_sum_q[EXT_W-1:0] << lzc;
            exp_n = exp_base - signed'(ESGN_W'(lzc));
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r   = {1'b0, norm[EXT_W-1:3]} + (SIG_W+1)'(round_up);
        // A rounding carry leaves 1.000..0, one binade higher.
        if (mant_r[SIG_W]) begin
            mant_f = mant_r[SIG_W-1:1];
            exp_r  = exp_n + 10'sd1;
        end else begin
            mant_f = mant_r[FRAC_W-1:0];
            exp_r  = exp_n;
        end
    end

    assign sum_zero = (s1_sum_q == '0);
    assign ovf_c    = !s1_special_q && !sum_zero && (exp_r >= 10'sd255);
    assign unf_c    = !s1_special_q && !sum_zero && (exp_r <= 10'sd0);

    always_comb begin : stage2_result
        out_d = {s1_sign_q, exp_r[EXP_W-1:0], mant_f};
        if (s1_special_q) begin
            out_d = s1_spec_val_q;
        end else if (sum_zero) begin
            out_d = '0;
        end else if (ovf_c) begin
            out_d = {s1_sign_q, EXP_MAX, FRAC_W'(0)};
        end else if (unf_c) begin
            out_d = {s1_sign_q, 31'd0};
        end
    end

    always_ff @(posedge clk) begin : stage2_regs
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_q <= out_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;

`ifdef FP_ADDER_FLAGS_EN
    logic       s1_invalid_q;
    logic       inexact_c;
    logic [3:0] flags_d, flags_q;

    assign inexact_c = !s1_special_q && !sum_zero && ((|norm[2:0]) || ovf_c || unf_c);

    always_comb begin : stage2_flags
        flags_d = {s1_special_q & s1_invalid_q, ovf_c, unf_c, inexact_c};
    end

    always_ff @(posedge clk) begin : flag_regs
        if (!rst_n) begin
            s1_invalid_q <= 1'b0;
            flags_q      <= '0;
        end else begin
            if (in_valid) begin
                s1_invalid_q <= s1_invalid_d;
            end
            if (s1_valid_q) begin
                flags_q <= flags_d;
            end
        end
    end

    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_fp_adder.sv
// Scoreboard bench for fp_adder: randomized operands checked against an exact-integer reference model.
module tb_fp_adder;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        logic [3:0]  flg;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] number_1;
    logic [31:0] number_2;
    logic        out_valid;
    logic [31:0] out;
`ifdef FP_ADDER_FLAGS_EN
    logic [3:0]  flags;
`endif

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          rst_hit = 1'b0;
    bit          armed   = 1'b0;
    logic [31:0] hold_val = 32'd0;
    logic [31:0] specials [8] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                  32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h7F7F_FFFF};

    fp_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .number_1  (number_1),
        .number_2  (number_2),
`ifdef FP_ADDER_FLAGS_EN
        .flags     (flags),
`endif
        .out_valid (out_valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Exact sum as an integer scaled by a power of two, then rounded to 24 bits.
    // Returns {invalid, overflow, underflow, inexact, result}.
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]  x, y;
        logic [127:0] mx, my, m, mant, rem, half;
        int           ex, ey, d, p, sh, e_res;
        logic         za, zb, ia, ib, na, nb, inexact;
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na || nb)                  return {4'b1000, QNAN};
        if (ia && ib && a[31] != b[31]) return {4'b1000, QNAN};
        if (ia)                        return {4'b0000, a};
        if (ib)                        return {4'b0000, b};
        if (za && zb)                  return {4'b0000, a[31] & b[31], 31'd0};
        if (za)                        return {4'b0000, b};
        if (zb)                        return {4'b0000, a};
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else                   begin x = a; y = b; end
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = 128'({1'b1, x[22:0]});
        my = 128'({1'b1, y[22:0]});
        d  = ex - ey;
        // A very distant operand only nudges the result; any tiny stand-in rounds identically.
        if (d > 60) begin d = 60; my = 128'd1; end
        m = (x[31] == y[31]) ? (mx << d) + my : (mx << d) - my;
        if (m == 128'd0) return 36'd0;
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        if (p > 23) begin
            sh      = p - 23;
            mant    = m >> sh;
            rem     = m & ((128'd1 << sh) - 128'd1);
            half    = 128'd1 << (sh - 1);
            inexact = (rem != 128'd0);
            if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
            if (mant == (128'd1 << 24)) begin mant = mant >> 1; sh++; end
        end else begin
            sh      = p - 23;
            mant    = m << (23 - p);
            inexact = 1'b0;
        end
        e_res = ex - d + sh;
        if (e_res >= 255) return {4'b0101, x[31], 8'hFF, 23'd0};
        if (e_res <= 0)   return {4'b0011, x[31], 31'd0};
        return {3'b000, inexact, x[31], 8'(e_res), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op(input logic [31:0] other);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 9))
            0:       r = specials[$urandom_range(0, 7)];
            1, 2:    r[30:23] = other[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
            3:       r = {~other[31], other[30:0] ^ 31'($urandom_range(0, 255))};
            4:       r[30:23] = 8'($urandom_range(1, 30));
            5:       r[30:23] = 8'($urandom_range(225, 254));
            default: ;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input bit use_const, input logic [31:0] cval);
        logic [35:0] r;
        @(posedge clk);
        #1;
        r        = ref_add(a, b);
        in_valid = 1'b1;
        number_1 = a;
        number_2 = b;
        sb.push_back('{a: a, b: b, val: use_const ? cval : r[31:0], flg: r[35:32], cyc: cyc});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            number_1 = $urandom;
            number_2 = $urandom;
        end
    endtask

    // Reset seen at an active edge: registers cleared, in-flight work discarded.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            rst_hit = 1'b1;
            armed   = 1'b1;
            sb.delete();
        end
    end

    always @(negedge clk) begin
        if (rst_hit) begin
            rst_hit = 1'b0;
            check32("reset_out", out, 32'd0);
            check_int("reset_out_valid", int'(out_valid), 0);
            hold_val = 32'd0;
        end else if (armed) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %08h, expected no output", out);
                end else begin
                    mon_e = sb.pop_front();
                    check32($sformatf("sum %08h+%08h", mon_e.a, mon_e.b), out, mon_e.val);
                    check_int("latency", cyc - mon_e.cyc, 2);
`ifdef FP_ADDER_FLAGS_EN
                    check32("flags", 32'(flags), 32'(mon_e.flg));
`endif
                end
                hold_val = out;
            end else begin
                check32("hold", out, hold_val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        number_1 = 32'd0;
        number_2 = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back triple, then the named corner cases.
        issue(32'h4020_0000, 32'h4060_0000, 1, 32'h40C0_0000);
        issue(32'h4013_3333, 32'h4060_0000, 1, 32'h40B9_999A);
        issue(32'h40A0_0000, 32'h4020_0000, 1, 32'h40F0_0000);
        idle(2);
        issue(32'h3F80_0000, 32'hBF80_0000, 1, 32'h0000_0000);
        issue(32'h7F80_0000, 32'hFF80_0000, 1, QNAN);
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1, 32'h7F80_0000);
        issue(32'h8000_0000, 32'h8000_0000, 1, 32'h8000_0000);
        issue(32'h0000_0001, 32'h3F80_0000, 1, 32'h3F80_0000);
        issue(32'h7FC0_1234, 32'h3F80_0000, 1, QNAN);
        issue(32'hFF80_0000, 32'h4120_0000, 1, 32'hFF80_0000);
        issue(32'h0080_0000, 32'h8080_0001, 1, 32'h8000_0000);
        issue(32'h3F80_0000, 32'h3380_0000, 1, 32'h3F80_0000);
        idle(3);

        // Reset with two operations in flight; the older one completes first.
        issue(32'h3F80_0000, 32'h4000_0000, 1, 32'h4040_0000);
        issue(32'h4040_0000, 32'h4040_0000, 1, 32'h40C0_0000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(6);

        for (int i = 0; i < 400; i++) begin
            a = rand_op(32'h3F80_0000);
            b = rand_op(a);
            if ($urandom_range(0, 3) == 0) idle(1);
            issue(a, b, 0, 32'd0);
        end
        idle(1);
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check_int("drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
